// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit type, maximum digit value and load clamp helper.
package bcd_pkg;
    typedef logic [3:0] bcd_digit_t;
    localparam bcd_digit_t BCD_MAX = 4'd9;
    function automatic bcd_digit_t bcd_clamp(input logic [3:0] n);
        return (n > BCD_MAX) ? BCD_MAX : n;
    endfunction
endpackage

// File: rtl/bcd_digit_updn.sv
// bcd_digit_updn: one up/down BCD digit with clear, clamped load and step enable.
module bcd_digit_updn
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_d,
    input  logic       en,
    input  logic       up,
    output logic [3:0] q,
    output logic       at_max,
    output logic       at_min
);
    bcd_digit_t q_d, q_q;
    always_comb begin
        q_d = clr ? 4'd0 : load ? bcd_clamp(load_d) : !en ? q_q :
              up ? ((q_q == BCD_MAX) ? 4'd0 : q_q + 4'd1) :
                   ((q_q == 4'd0) ? BCD_MAX : q_q - 4'd1);
    end
    always_ff @(posedge clk) begin
        if (rst) q_q <= 4'd0;
        else     q_q <= q_d;
    end
    assign q      = q_q;
    assign at_max = (q_q == BCD_MAX);
    assign at_min = (q_q == 4'd0);
endmodule

// File: rtl/bcd_time_counter_n.sv
// bcd_time_counter_n: N-digit up/down BCD counter with preset load, lap capture,
// wrap or saturate at terminal count, sticky late flag and terminal-count pulse.
module bcd_time_counter_n
    import bcd_pkg::*;
#(
    parameter int NDIGITS  = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   en,
    input  logic                   up,
    input  logic                   load,
    input  logic [4*NDIGITS-1:0]   load_val,
    input  logic                   lap,
    output logic [4*NDIGITS-1:0]   q,
    output logic [4*NDIGITS-1:0]   lap_q,
    output logic                   late,
    output logic                   tc,
    output logic                   zero
);
    logic [NDIGITS-1:0] at_max, at_min, step;
    logic [4*NDIGITS-1:0] lap_d;
    logic term, late_d, late_q, tc_d, tc_q;

    // The whole count is at its end for the current direction and a step is requested.
    assign term = en && (up ? &at_max : &at_min);

    for (genvar i = 0; i < NDIGITS; i++) begin : g_digit
        if (i == 0) begin : g_lsd
            assign step[i] = en && !(SATURATE && term);
        end else begin : g_hi
            assign step[i] = step[i-1] && (up ? at_max[i-1] : at_min[i-1]);
        end
        bcd_digit_updn u_digit (
            .clk    (clk),
            .rst    (rst),
            .clr    (clr),
            .load   (load),
            .load_d (load_val[4*i +: 4]),
            .en     (step[i]),
            .up     (up),
            .q      (q[4*i +: 4]),
            .at_max (at_max[i]),
            .at_min (at_min[i])
        );
    end

    always_comb begin
        lap_d  = clr ? '0 : lap ? q : lap_q;
        late_d = (clr || load) ? 1'b0 : (late_q || term);
        tc_d   = !clr && !load && term;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            lap_q  <= '0;
            late_q <= 1'b0;
            tc_q   <= 1'b0;
        end else begin
            lap_q  <= lap_d;
            late_q <= late_d;
            tc_q   <= tc_d;
        end
    end
    assign late = late_q;
    assign tc   = tc_q;
    assign zero = &at_min;
endmodule

// File: tb/tb_bcd_time_counter_n.sv
// tb_bcd_time_counter_n: directed and randomized checks of three counter variants
// against an integer-arithmetic reference model.
module tb_bcd_time_counter_n;
    logic clk = 1'b0;
    logic rst, clr, en, up, load, lap;
    logic [15:0] load_val;
    logic [15:0] q0, q1, lq0, lq1;
    logic [3:0]  q2, lq2;
    logic late0, late1, late2, tc0, tc1, tc2, zero0, zero1, zero2;
    int checks = 0, errors = 0;
    int nd[3]  = '{4, 4, 1};
    bit sat[3] = '{1'b0, 1'b1, 1'b0};
    int m[3], lapm[3];
    bit latem[3], tcm[3];

    always #5 clk = ~clk;

    bcd_time_counter_n #(.NDIGITS(4), .SATURATE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .up(up), .load(load), .load_val(load_val),
        .lap(lap), .q(q0), .lap_q(lq0), .late(late0), .tc(tc0), .zero(zero0));
    bcd_time_counter_n #(.NDIGITS(4), .SATURATE(1'b1)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .up(up), .load(load), .load_val(load_val),
        .lap(lap), .q(q1), .lap_q(lq1), .late(late1), .tc(tc1), .zero(zero1));
    bcd_time_counter_n #(.NDIGITS(1), .SATURATE(1'b0)) dut2 (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .up(up), .load(load), .load_val(load_val[3:0]),
        .lap(lap), .q(q2), .lap_q(lq2), .late(late2), .tc(tc2), .zero(zero2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int from_load(input logic [15:0] lv, input int n);
        int v = 0, p = 1;
        logic [3:0] nib;
        for (int i = 0; i < n; i++) begin
            nib = lv[4*i +: 4];
            v += ((nib > 9) ? 9 : int'(nib)) * p;
            p *= 10;
        end
        return v;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v /= 10;
        end
        return r;
    endfunction

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            int mx = (nd[k] == 4) ? 9999 : 9;
            if (rst || clr) begin
                m[k] = 0; lapm[k] = 0; latem[k] = 0; tcm[k] = 0;
            end else begin
                if (lap) lapm[k] = m[k];
                if (load) begin
                    m[k] = from_load(load_val, nd[k]); latem[k] = 0; tcm[k] = 0;
                end else if (en) begin
                    if (up ? (m[k] == mx) : (m[k] == 0)) begin
                        tcm[k] = 1; latem[k] = 1;
                        if (!sat[k]) m[k] = up ? 0 : mx;
                    end else begin
                        tcm[k] = 0;
                        m[k] = up ? m[k] + 1 : m[k] - 1;
                    end
                end else tcm[k] = 0;
            end
        end
    endtask

    task automatic cyc();
        logic [15:0] gq, glq;
        logic gl, gt, gz;
        @(posedge clk);
        model_step();
        #1;
        for (int k = 0; k < 3; k++) begin
            gq  = (k == 0) ? q0 : (k == 1) ? q1 : {12'h0, q2};
            glq = (k == 0) ? lq0 : (k == 1) ? lq1 : {12'h0, lq2};
            gl  = (k == 0) ? late0 : (k == 1) ? late1 : late2;
            gt  = (k == 0) ? tc0 : (k == 1) ? tc1 : tc2;
            gz  = (k == 0) ? zero0 : (k == 1) ? zero1 : zero2;
            check($sformatf("q%0d", k), 32'(gq), 32'(to_bcd(m[k])));
            check($sformatf("lap_q%0d", k), 32'(glq), 32'(to_bcd(lapm[k])));
            check($sformatf("late%0d", k), 32'(gl), 32'(latem[k]));
            check($sformatf("tc%0d", k), 32'(gt), 32'(tcm[k]));
            check($sformatf("zero%0d", k), 32'(gz), 32'(m[k] == 0));
        end
    endtask

    task automatic drive(input logic r, c, l, e, u, lp, input logic [15:0] lv);
        rst = r; clr = c; load = l; en = e; up = u; lap = lp; load_val = lv;
    endtask

    initial begin
        int r;
        logic [15:0] picks[5] = '{16'h9998, 16'h0002, 16'h9999, 16'h0000, 16'h0001};
        drive(1, 0, 0, 0, 1, 0, 16'h0);
        cyc();
        check("reset_q", 32'(q0), 32'h0);
        drive(0, 0, 0, 1, 1, 0, 16'h0);
        repeat (1234) cyc();
        check("t1_q", 32'(q0), 32'h1234);
        check("t1_late", 32'(late0), 32'h0);
        drive(0, 0, 1, 0, 1, 0, 16'h9998); cyc();
        drive(0, 0, 0, 1, 1, 0, 16'h0);    cyc();
        check("t2_9999", 32'(q0), 32'h9999);
        cyc();
        check("t2_wrap_q", 32'(q0), 32'h0);
        check("t2_wrap_tc", 32'(tc0), 32'h1);
        check("t2_wrap_late", 32'(late0), 32'h1);
        cyc();
        check("t2_next_q", 32'(q0), 32'h1);
        check("t2_next_tc", 32'(tc0), 32'h0);
        drive(0, 0, 1, 0, 0, 0, 16'h0002); cyc();
        drive(0, 0, 0, 1, 0, 0, 16'h0);
        repeat (5) cyc();
        check("t3_hold_q", 32'(q1), 32'h0);
        check("t3_hold_tc", 32'(tc1), 32'h1);
        check("t3_hold_late", 32'(late1), 32'h1);
        drive(0, 0, 1, 0, 0, 0, 16'h0500); cyc();
        check("t3_load_late", 32'(late1), 32'h0);
        drive(0, 0, 1, 1, 1, 0, 16'hFA37); cyc();
        check("t4_clamp", 32'(q0), 32'h9937);
        drive(0, 0, 1, 0, 1, 0, 16'h0457); cyc();
        drive(0, 0, 0, 1, 1, 1, 16'h0);    cyc();
        check("t5_lap", 32'(lq0), 32'h0457);
        check("t5_q", 32'(q0), 32'h0458);
        drive(0, 1, 0, 1, 1, 1, 16'h0);    cyc();
        check("t5_clr_q", 32'(q0), 32'h0);
        check("t5_clr_lap", 32'(lq0), 32'h0);
        drive(0, 0, 0, 1, 0, 0, 16'h0);    cyc();
        check("t6_q2", 32'(q2), 32'h9);
        check("t6_tc2", 32'(tc2), 32'h1);
        drive(1, 0, 0, 1, 0, 0, 16'h0);    cyc();
        check("t6_rst_tc", 32'(tc2), 32'h0);
        for (int n = 0; n < 4000; n++) begin
            r = int'($urandom_range(0, 199));
            rst  = (r < 2);
            clr  = (r >= 2 && r < 6);
            load = (r >= 6 && r < 20);
            lap  = ($urandom_range(0, 9) == 0);
            en   = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) up = ~up;
            load_val = ($urandom_range(0, 1) == 0) ? 16'($urandom) : picks[$urandom_range(0, 4)];
            cyc();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
